// File: rtl/en_strobe_gen_if.sv
// Handshake/status bundle for en_strobe_gen. The optional strobe_cnt signal is
// present only when EN_STROBE_GEN_CNT_EN is defined.
interface en_strobe_gen_if #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DIV_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               en;
  logic               busy;
  logic               done;
`ifdef EN_STROBE_GEN_CNT_EN
  logic [BURST_W-1:0] strobe_cnt;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, en, busy, done, strobe_cnt
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, en, busy, done, strobe_cnt
  );
`else
  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, en, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, en, busy, done
  );
`endif
endinterface

// File: rtl/en_strobe_gen.sv
// Programmable enable-strobe generator: divides clk by div+1, free-running or as a
// burst of N strobes. Optional strobe_cnt output when EN_STROBE_GEN_CNT_EN is defined.
module en_strobe_gen #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 4
) (
  input  logic            clk,
  input  logic            rstn,
  en_strobe_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [BURST_W-1:0] burst_r, burst_s;
  logic [DIV_W-1:0]   pre_r, pre_s;
  logic [BURST_W-1:0] cnt_r, cnt_s;
  logic [BURST_W-1:0] cnt_inc_s;
  logic               en_r, en_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // Next-state and next-output decode for the run controller
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    burst_s   = burst_r;
    pre_s     = pre_r;
    cnt_s     = cnt_r;
    en_s      = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    cnt_inc_s = cnt_r + BURST_W'(1);

    case (state_r)
      ST_IDLE: begin
        // A config offered alongside start is taken first, so the run sees it
        div_s   = bus.cfg_valid ? bus.cfg_div   : div_r;
        burst_s = bus.cfg_valid ? bus.cfg_burst : burst_r;
        if (bus.start) begin
          state_s = ST_RUN;
          pre_s   = div_s;
          cnt_s   = {BURST_W{1'b0}};
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end else if (pre_r == {DIV_W{1'b0}}) begin
          en_s  = 1'b1;
          pre_s = div_r;
          cnt_s = cnt_inc_s;
          if ((burst_r != {BURST_W{1'b0}}) && (cnt_inc_s == burst_r)) begin
            state_s = ST_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
            busy_s  = 1'b1;
          end
        end else begin
          pre_s   = pre_r - DIV_W'(1);
          state_s = ST_RUN;
          busy_s  = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, configuration and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      div_r   <= {DIV_W{1'b0}};
      burst_r <= {BURST_W{1'b0}};
      pre_r   <= {DIV_W{1'b0}};
      cnt_r   <= {BURST_W{1'b0}};
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      burst_r <= burst_s;
      pre_r   <= pre_s;
      cnt_r   <= cnt_s;
      en_r    <= en_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.cfg_ready = (state_r == ST_IDLE);
  assign bus.en        = en_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

`ifdef EN_STROBE_GEN_CNT_EN
  assign bus.strobe_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_en_strobe_gen.sv
// Directed scoreboard bench for en_strobe_gen: per-cycle expectations are queued
// as stimulus is driven and popped when the outputs are sampled after the edge.
module tb_en_strobe_gen;

  logic clk = 1'b0;
  logic rstn = 1'b1;

  en_strobe_gen_if #(.DIV_W(8), .BURST_W(4)) bus ();

  en_strobe_gen #(.DIV_W(8), .BURST_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  en;
    logic  busy;
    logic  done;
    logic  rdy;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_bit({e.tag, ".en"},        bus.en,        e.en);
    check_bit({e.tag, ".busy"},      bus.busy,      e.busy);
    check_bit({e.tag, ".done"},      bus.done,      e.done);
    check_bit({e.tag, ".cfg_ready"}, bus.cfg_ready, e.rdy);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic cyc(input logic cv, input logic [7:0] d, input logic [3:0] b,
                     input logic st, input logic sp,
                     input logic e_en, input logic e_busy, input logic e_done,
                     input logic e_rdy, input string tag);
    exp_t e;
    bus.cfg_valid = cv;
    bus.cfg_div   = d;
    bus.cfg_burst = b;
    bus.start     = st;
    bus.stop      = sp;
    e.en = e_en; e.busy = e_busy; e.done = e_done; e.rdy = e_rdy; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard: queue empty, expected 1 entry");
    end else begin
      check_outputs(exp_q.pop_front());
    end
  endtask

  task automatic idle(input logic e_en, input logic e_busy, input logic e_done,
                      input logic e_rdy, input string tag);
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b0, e_en, e_busy, e_done, e_rdy, tag);
  endtask

  initial begin
    exp_t r;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = 8'd0;
    bus.cfg_burst = 4'd0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    #1 rstn = 1'b0;

    // Reset held 3 cycles while a config is offered: nothing may be latched
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'd9, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    rstn = 1'b1;

    // Start with reset config: div 0, burst 0 -> en every cycle
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_start");
    for (int t = 1; t <= 5; t++) idle(1'b1, 1'b1, 1'b0, 1'b0, "rst_freerun");
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "rst_stop");

    // Burst div 3 x 4; stop in IDLE must be ignored
    cyc(1'b1, 8'd3, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "burst_cfg");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "burst_start");
    for (int t = 1; t <= 16; t++)
      idle((t % 4) == 0, t < 16, t == 16, 1'b0, "burst_run");
    idle(1'b0, 1'b0, 1'b0, 1'b1, "burst_end");
    idle(1'b0, 1'b0, 1'b0, 1'b1, "burst_idle");

    // Free-run div 0 for 20 cycles, then stop
    cyc(1'b1, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "free_cfg");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "free_start");
    for (int t = 1; t <= 20; t++) idle(1'b1, 1'b1, 1'b0, 1'b0, "free_run");
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "free_stop");
    for (int t = 0; t < 3; t++) idle(1'b0, 1'b0, 1'b0, 1'b1, "free_after");

    // Stop coinciding with the final burst strobe: stop wins
    cyc(1'b1, 8'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "coll_cfg");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "coll_start");
    for (int t = 1; t <= 5; t++) idle(t == 3, 1'b1, 1'b0, 1'b0, "coll_run");
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "coll_stop");
    for (int t = 0; t < 2; t++) idle(1'b0, 1'b0, 1'b0, 1'b1, "coll_after");

    // Config lockout: div 1 free-run keeps period 2 while div 7 / burst 3 is offered
    cyc(1'b1, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "lock_cfg");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lock_start");
    for (int t = 1; t <= 8; t++)
      cyc(1'b1, 8'd7, 4'd3, 1'b1, 1'b0, (t % 2) == 0, 1'b1, 1'b0, 1'b0, "lock_run");
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "lock_stop");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lock_restart");
    for (int t = 1; t <= 8; t++) idle((t % 2) == 0, 1'b1, 1'b0, 1'b0, "lock_rerun");
    cyc(1'b0, 8'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "lock_stop2");

    // Same-cycle config + start, div 5 burst 1; start during DONE is ignored
    cyc(1'b1, 8'd5, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "same_start");
    for (int t = 1; t <= 6; t++) idle(t == 6, t < 6, t == 6, 1'b0, "same_run");
    cyc(1'b0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "same_done_start");
    idle(1'b0, 1'b0, 1'b0, 1'b1, "same_idle");

    // Asynchronous reset in the middle of a free run
    cyc(1'b1, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "arst_start");
    for (int t = 1; t <= 3; t++) idle(1'b1, 1'b1, 1'b0, 1'b0, "arst_run");
    #2 rstn = 1'b0;
    #1;
    r.en = 1'b0; r.busy = 1'b0; r.done = 1'b0; r.rdy = 1'b1; r.tag = "arst_now";
    check_outputs(r);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) idle(1'b0, 1'b0, 1'b0, 1'b1, "arst_hold");
    rstn = 1'b1;
    idle(1'b0, 1'b0, 1'b0, 1'b1, "arst_release");

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
